// File: rtl/hamming_dec_seq_if.sv
// Bus bundle between the sequential Hamming(16,11) decoder and its host/memory.
// The decoder sits on the slave side; the host/memory model sits on the master side.
interface hamming_dec_seq_if;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic [3:0] sgl_cnt;
  logic [3:0] dbl_cnt;

  modport slave (
    input  start, mem_rd_data,
    output done, mem_addr, mem_wr_en, mem_wr_data, sgl_cnt, dbl_cnt
  );

  modport master (
    output start, mem_rd_data,
    input  done, mem_addr, mem_wr_en, mem_wr_data, sgl_cnt, dbl_cnt
  );
endinterface

// File: rtl/hamming_dec_seq.sv
// Sequential SECDED Hamming(16,11) decoder: reads NUM_WORDS codewords from memory,
// corrects single errors, flags double errors, and writes data plus a status flag back.
module hamming_dec_seq #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  hamming_dec_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DEC, WR_LO, WR_HI, DONE} state_t;

  localparam logic [7:0] SRC8 = 8'(SRC_BASE);
  localparam logic [7:0] DST8 = 8'(DST_BASE);
  localparam logic [7:0] LAST = 8'(NUM_WORDS - 1);

  state_t      r_state;
  logic [7:0]  r_i;
  logic [15:0] r_w;
  logic [1:0]  r_flag;
  logic [2:0]  r_hi3;
  logic        r_done;
  logic        r_wr_en;
  logic [7:0]  r_addr;
  logic [7:0]  r_wr_data;
  logic [3:0]  r_sgl;
  logic [3:0]  r_dbl;

  logic [3:0]  w_term [1:15];
  logic [3:0]  w_syn;
  logic        w_par;
  logic [15:0] w_fix;
  logic [1:0]  w_flag;
  logic [7:0]  w_src_lo;
  logic [7:0]  w_src_next;
  logic [7:0]  w_dst_lo;

  // Each set bit contributes its own position index to the syndrome.
  generate
    for (genvar gi = 1; gi < 16; gi++) begin : g_term
      assign w_term[gi] = r_w[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  always_comb begin
    w_syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      w_syn = w_syn ^ w_term[k];
    end
  end

  assign w_par = ^r_w;

  // A syndrome of zero with odd parity means p0 itself flipped: data stays as read.
  assign w_fix  = r_w ^ ((w_par && (w_syn != 4'd0)) ? (16'd1 << w_syn) : 16'd0);
  assign w_flag = w_par ? 2'b01 : ((w_syn != 4'd0) ? 2'b10 : 2'b00);

  assign w_src_lo   = SRC8 + {r_i[6:0], 1'b0};
  assign w_src_next = SRC8 + {r_i[6:0] + 7'd1, 1'b0};
  assign w_dst_lo   = DST8 + {r_i[6:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_i       <= 8'd0;
      r_w       <= 16'd0;
      r_flag    <= 2'b00;
      r_hi3     <= 3'd0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= 8'd0;
      r_wr_data <= 8'd0;
      r_sgl     <= 4'd0;
      r_dbl     <= 4'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= RD_LO;
            r_i     <= 8'd0;
            r_sgl   <= 4'd0;
            r_dbl   <= 4'd0;
            r_done  <= 1'b0;
            r_addr  <= SRC8;
          end else if (r_state == DONE) begin
            r_done <= 1'b1;
          end
        end
        RD_LO: begin
          r_w[7:0] <= bus.mem_rd_data;
          r_addr   <= w_src_lo + 8'd1;
          r_state  <= RD_HI;
        end
        RD_HI: begin
          r_w[15:8] <= bus.mem_rd_data;
          r_addr    <= 8'd0;
          r_state   <= DEC;
        end
        DEC: begin
          r_flag    <= w_flag;
          r_hi3     <= w_fix[15:13];
          if (w_flag == 2'b01 && r_sgl != 4'hF) r_sgl <= r_sgl + 4'd1;
          if (w_flag == 2'b10 && r_dbl != 4'hF) r_dbl <= r_dbl + 4'd1;
          r_wr_en   <= 1'b1;
          r_addr    <= w_dst_lo;
          r_wr_data <= {w_fix[12:9], w_fix[7:5], w_fix[3]};
          r_state   <= WR_LO;
        end
        WR_LO: begin
          r_addr    <= w_dst_lo + 8'd1;
          r_wr_data <= {r_flag, 3'b000, r_hi3};
          r_state   <= WR_HI;
        end
        WR_HI: begin
          r_wr_en   <= 1'b0;
          r_wr_data <= 8'd0;
          if (r_i < LAST) begin
            r_i     <= r_i + 8'd1;
            r_addr  <= w_src_next;
            r_state <= RD_LO;
          end else begin
            r_addr  <= 8'd0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.done        = r_done;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_data = r_wr_data;
  assign bus.sgl_cnt     = r_sgl;
  assign bus.dbl_cnt     = r_dbl;
endmodule
